// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: two-digit BCD operand entry from switches/buttons,
// range-checked and handed off downstream with a valid/ready handshake.

// Per-button conditioning: capture, two-flop synchroniser, debounce, press strobe.
module bcd_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic strobe
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    sync;  // [0] input capture, [2] synchronised level s
  logic          s;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  assign s = sync[2];

  // Input capture followed by the two-flop synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], raw};
  end

  // Accept a new level only after s has disagreed with db for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s == db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      db  <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // One-cycle strobe on each debounced press; releases are silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      db_q   <= db;
      strobe <= db & ~db_q;
    end
  end
endmodule

module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_VALUE       = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       btn_push,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       bcd_ready,
  output logic [7:0] bcd_out,
  output logic       bcd_valid,
  output logic [7:0] entry_bcd,
  output logic [1:0] digit_count,
  output logic       err
);
  localparam int NUM_BTN = 3;
  localparam int B_PUSH  = 0;
  localparam int B_ENTER = 1;
  localparam int B_CLEAR = 2;
  localparam logic [7:0] MAXV = 8'(MAX_VALUE);

  typedef enum logic [1:0] {EMPTY, ONE, TWO, HOLD} state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] stb;
  state_t             state, state_nx;
  logic [7:0]         entry_nx;
  logic [7:0]         out_nx;
  logic               err_nx;
  logic [7:0]         value;
  logic               bad_digit;

  assign raw = {btn_clear, btn_enter, btn_push};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    bcd_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw[i]),
      .strobe (stb[i])
    );
  end

  // Decimal value of the typed entry and digit legality.
  assign value     = 8'(entry_bcd[7:4]) * 8'd10 + 8'(entry_bcd[3:0]);
  assign bad_digit = digit_in > 4'd9;

  // Entry state, committed operand and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      entry_bcd <= '0;
      bcd_out   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      entry_bcd <= entry_nx;
      bcd_out   <= out_nx;
      err       <= err_nx;
    end
  end

  // Event handling: clear beats the handshake/enter, enter beats push.
  always_comb begin
    state_nx = state;
    entry_nx = entry_bcd;
    out_nx   = bcd_out;
    err_nx   = err;
    if (stb[B_CLEAR]) begin
      state_nx = EMPTY;
      entry_nx = '0;
      err_nx   = 1'b0;
    end else if (state == HOLD) begin
      // push/enter ignored until the operand is collected
      if (bcd_ready) begin
        state_nx = EMPTY;
        entry_nx = '0;
      end
    end else if (stb[B_ENTER]) begin
      if (state != EMPTY) begin
        if (value <= MAXV) begin
          out_nx   = entry_bcd;
          state_nx = HOLD;
          err_nx   = 1'b0;
        end else begin
          err_nx = 1'b1;
        end
      end
    end else if (stb[B_PUSH]) begin
      if (bad_digit) begin
        err_nx = 1'b1;
      end else if (state == EMPTY) begin
        entry_nx = {4'h0, digit_in};
        state_nx = ONE;
      end else begin
        entry_nx = {entry_bcd[3:0], digit_in};
        state_nx = TWO;
      end
    end
  end

  // Status decode straight from the state register.
  always_comb begin
    bcd_valid = (state == HOLD);
    case (state)
      EMPTY:   digit_count = 2'd0;
      ONE:     digit_count = 2'd1;
      default: digit_count = 2'd2;
    endcase
  end
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry: directed button sequences, an event-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_bcd_operand_entry;
  localparam int DC   = 4;
  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_in = 4'h0;
  logic       btn_push = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic       bcd_ready = 1'b0;
  logic [7:0] bcd_out, entry_bcd;
  logic       bcd_valid, err;
  logic [1:0] digit_count;

  int n_tests = 0;
  int n_fail  = 0;
  int vhi     = 0;

  always #5 clk = ~clk;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DC), .MAX_VALUE(MAXV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .btn_push    (btn_push),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .bcd_ready   (bcd_ready),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .entry_bcd   (entry_bcd),
    .digit_count (digit_count),
    .err         (err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button's level flips once the last DC synchronised samples all disagree
  // with it; the synchronised sample used at an edge is the raw level captured
  // three edges earlier. A rising flip acts on the entry two edges later.
  logic [7:0] hist [3];
  bit         lvl  [3];
  bit   [1:0] evq  [3];
  int         m_ndig;
  logic [3:0] m_tens, m_ones;
  bit         m_hold, m_err;
  logic [7:0] m_out;

  initial begin
    bit         all_diff;
    logic [2:0] rawv, act;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int b = 0; b < 3; b++) begin
          hist[b] = '0; lvl[b] = 1'b0; evq[b] = '0;
        end
        m_ndig = 0; m_tens = '0; m_ones = '0;
        m_hold = 1'b0; m_err = 1'b0; m_out = '0;
      end else begin
        rawv = {btn_clear, btn_enter, btn_push};
        act  = '0;
        for (int b = 0; b < 3; b++) begin
          act[b]   = evq[b][1];
          all_diff = 1'b1;
          for (int k = 0; k < DC; k++)
            if (hist[b][2+k] == lvl[b]) all_diff = 1'b0;
          evq[b]  = {evq[b][0], all_diff & ~lvl[b]};
          if (all_diff) lvl[b] = ~lvl[b];
          hist[b] = {hist[b][6:0], rawv[b]};
        end
        if (act[2]) begin
          m_ndig = 0; m_tens = '0; m_ones = '0; m_err = 1'b0; m_hold = 1'b0;
        end else if (m_hold) begin
          if (bcd_ready) begin
            m_hold = 1'b0; m_ndig = 0; m_tens = '0; m_ones = '0;
          end
        end else if (act[1]) begin
          if (m_ndig > 0) begin
            if (int'(m_tens) * 10 + int'(m_ones) <= MAXV) begin
              m_out = {m_tens, m_ones}; m_hold = 1'b1; m_err = 1'b0;
            end else begin
              m_err = 1'b1;
            end
          end
        end else if (act[0]) begin
          if (digit_in > 4'd9) m_err = 1'b1;
          else begin
            m_tens = (m_ndig == 0) ? 4'h0 : m_ones;
            m_ones = digit_in;
            m_ndig = (m_ndig == 0) ? 1 : 2;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  initial begin
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cmp_entry", entry_bcd, {m_tens, m_ones});
        check("cmp_count", {6'b0, digit_count}, 8'(m_hold ? 2 : m_ndig));
        check("cmp_valid", {7'b0, bcd_valid}, {7'b0, m_hold});
        check("cmp_out",   bcd_out, m_out);
        check("cmp_err",   {7'b0, err}, {7'b0, m_err});
      end
    end
  end

  // ---------------- stimulus ----------------
  // mask = {clear, enter, push}; buttons held ncyc cycles, then released and settled.
  task automatic press(input logic [2:0] mask, input int ncyc, input logic [3:0] d);
    digit_in = d;
    {btn_clear, btn_enter, btn_push} = mask;
    repeat (ncyc) begin
      @(negedge clk);
      vhi += int'(bcd_valid);
    end
    {btn_clear, btn_enter, btn_push} = 3'b000;
    repeat (14) begin
      @(negedge clk);
      vhi += int'(bcd_valid);
    end
  endtask

  task automatic take();
    bcd_ready = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_entry", entry_bcd, 8'h00);
    check("rst_count", {6'b0, digit_count}, 8'd0);
    check("rst_valid", {7'b0, bcd_valid}, 8'd0);
    check("rst_out",   bcd_out, 8'h00);
    check("rst_err",   {7'b0, err}, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 1,2 enter, then one-cycle ready
    press(3'b001, 6, 4'd1);
    press(3'b001, 6, 4'd2);
    check("s1_entry", entry_bcd, 8'h12);
    press(3'b010, 6, 4'd2);
    check("s1_valid", {7'b0, bcd_valid}, 8'd1);
    check("s1_out",   bcd_out, 8'h12);
    check("s1_count", {6'b0, digit_count}, 8'd2);
    check("s1_model_out", m_out, 8'h12);
    take();
    check("s1_taken_valid", {7'b0, bcd_valid}, 8'd0);
    check("s1_taken_entry", entry_bcd, 8'h00);
    check("s1_taken_out",   bcd_out, 8'h12);

    // 2: 3,4,7 shifts, enter out of range, clear
    press(3'b001, 6, 4'd3);
    check("s2_e03", entry_bcd, 8'h03);
    press(3'b001, 6, 4'd4);
    check("s2_e34", entry_bcd, 8'h34);
    press(3'b001, 6, 4'd7);
    check("s2_e47", entry_bcd, 8'h47);
    press(3'b010, 6, 4'd7);
    check("s2_err",   {7'b0, err}, 8'd1);
    check("s2_valid", {7'b0, bcd_valid}, 8'd0);
    check("s2_keep",  entry_bcd, 8'h47);
    press(3'b100, 6, 4'd0);
    check("s2_clr_err",   {7'b0, err}, 8'd0);
    check("s2_clr_count", {6'b0, digit_count}, 8'd0);

    // 3: illegal digit, then 9 enter
    press(3'b001, 6, 4'hA);
    check("s3_err",   {7'b0, err}, 8'd1);
    check("s3_entry", entry_bcd, 8'h00);
    press(3'b001, 6, 4'd9);
    press(3'b010, 6, 4'd9);
    check("s3_out", bcd_out, 8'h09);
    check("s3_err_clr", {7'b0, err}, 8'd0);
    take();

    // 4: 3-cycle glitch ignored; 4-cycle press lands at edge 8
    press(3'b001, 3, 4'd7);
    check("s4_glitch", entry_bcd, 8'h00);
    digit_in = 4'd5;
    btn_push = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) btn_push = 1'b0;
      if (k == 7) check("s4_edge7", entry_bcd, 8'h00);
      if (k == 8) check("s4_edge8", entry_bcd, 8'h05);
    end
    repeat (12) @(negedge clk);

    // 5: enter+clear together -> clear wins, bcd_out kept
    press(3'b110, 6, 4'd5);
    check("s5_entry", entry_bcd, 8'h00);
    check("s5_valid", {7'b0, bcd_valid}, 8'd0);
    check("s5_out",   bcd_out, 8'h09);
    // ready held high: operand valid for exactly one cycle
    bcd_ready = 1'b1;
    press(3'b001, 6, 4'd1);
    press(3'b001, 6, 4'd4);
    vhi = 0;
    press(3'b010, 6, 4'd4);
    check("s5_valid_cycles", 8'(vhi), 8'd1);
    check("s5_out14", bcd_out, 8'h14);
    bcd_ready = 1'b0;

    // 6: async reset in HOLD
    press(3'b001, 6, 4'd1);
    press(3'b001, 6, 4'd5);
    press(3'b010, 6, 4'd5);
    check("s6_hold_out", bcd_out, 8'h15);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_out",   bcd_out, 8'h00);
    check("s6_rst_valid", {7'b0, bcd_valid}, 8'd0);
    check("s6_rst_entry", entry_bcd, 8'h00);
    check("s6_rst_count", {6'b0, digit_count}, 8'd0);
    // button held across reset: press counted only after full debounce
    digit_in = 4'd3;
    btn_push = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("s6_held_early", entry_bcd, 8'h00);
    repeat (3) @(negedge clk);
    check("s6_held_late", entry_bcd, 8'h03);
    btn_push = 1'b0;
    repeat (14) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
